// File: rtl/rt_frame_scheduler_pkg.sv
// Shared types and constants for the ray-tracer frame scheduler.
package rt_frame_scheduler_pkg;

    // Width of one light-position component.
    localparam int LOC_W = 32;

    // Reset light position: cube root of 2 in unsigned Q16.16 (1.259921 * 65536).
    localparam logic [LOC_W-1:0] QCBRT_2 = 32'h0001_428A;

    // Light position bundle.
    typedef struct packed {
        logic [LOC_W-1:0] x;
        logic [LOC_W-1:0] y;
        logic [LOC_W-1:0] z;
    } vec3_t;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FSTART    = 3'd1,
        ST_WAIT_CRED = 3'd2,
        ST_RUN       = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_FDONE     = 3'd5
    } sched_state_t;

    // Bits needed to hold a coordinate in 0..n-1 (at least one bit).
    function automatic int coord_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rt_frame_scheduler_credit_counter.sv
// Saturating up/down counter of free framebuffer row buffers.
module rt_credit_counter #(
    parameter int CREDITS = 2,
    localparam int CNT_W  = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             take,
    input  logic             give,
    output logic             avail,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // A credit arriving this cycle can be spent this cycle, so a stalled row
    // issues on the cycle right after the return pulse.
    assign avail = (count_reg != '0) || give;
    assign count = count_reg;

    // Take and give together cancel; a give at full count is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= CNT_W'(CREDITS);
        end else if (take && !give && (count_reg != '0)) begin
            count_reg <= count_reg - CNT_W'(1);
        end else if (give && !take && (count_reg != CNT_W'(CREDITS))) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rt_frame_scheduler.sv
// Frame/row sequencer for the ray-tracer pixel pipeline: issues rows of run
// strobes gated by framebuffer credits and holds the light position per frame.
module rt_frame_scheduler
    import rt_frame_scheduler_pkg::*;
#(
    parameter int X_PIXELS  = 320,
    parameter int Y_PIXELS  = 240,
    parameter int PIPE_LEN  = 23,
    parameter int CREDITS   = 2,
    parameter int LOC_WIDTH = 32    // must equal LOC_W (vec3_t field width)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable_i,
    input  logic                              fb_row_free_i,
    input  logic [LOC_WIDTH-1:0]              l_loc_x_i,
    input  logic [LOC_WIDTH-1:0]              l_loc_y_i,
    input  logic [LOC_WIDTH-1:0]              l_loc_z_i,
    output logic                              run_o,
    output logic [coord_width(X_PIXELS)-1:0]  x_coord_o,
    output logic [coord_width(Y_PIXELS)-1:0]  y_coord_o,
    output logic                              row_start_o,
    output logic                              frame_start_o,
    output logic                              frame_done_o,
    output logic [LOC_WIDTH-1:0]              l_loc_x_o,
    output logic [LOC_WIDTH-1:0]              l_loc_y_o,
    output logic [LOC_WIDTH-1:0]              l_loc_z_o,
    output logic                              busy_o
);

    localparam int X_W     = coord_width(X_PIXELS);
    localparam int Y_W     = coord_width(Y_PIXELS);
    localparam int DRAIN_W = coord_width(PIPE_LEN);
    localparam int CNT_W   = $clog2(CREDITS + 1);

    sched_state_t     state_reg;
    logic [X_W-1:0]   x_reg;
    logic [Y_W-1:0]   y_reg;
    logic [DRAIN_W-1:0] drain_reg;
    logic             run_reg;
    logic             row_start_reg;
    logic             frame_start_reg;
    logic             frame_done_reg;
    logic             busy_reg;
    vec3_t            light_reg;

    logic             credit_avail;
    logic [CNT_W-1:0] credit_count;
    logic             credit_overflow_reg;
    logic             issue;

    // A row is issued on the WAIT_CRED cycle that sees a credit.
    assign issue = (state_reg == ST_WAIT_CRED) && credit_avail;

    rt_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk   (clk),
        .rst   (rst),
        .take  (issue),
        .give  (fb_row_free_i),
        .avail (credit_avail),
        .count (credit_count)
    );

    // Sticky record of a credit return while every row buffer was already free.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_overflow_reg <= 1'b0;
        end else begin
            credit_overflow_reg <= credit_overflow_reg
                                 | (fb_row_free_i && !issue && (credit_count == CNT_W'(CREDITS)));
        end
    end

    // Frame FSM; every output is registered alongside the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            x_reg           <= '0;
            y_reg           <= '0;
            drain_reg       <= '0;
            run_reg         <= 1'b0;
            row_start_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            light_reg       <= '{x: QCBRT_2, y: QCBRT_2, z: QCBRT_2};
        end else begin
            row_start_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_reg       <= ST_FSTART;
                        frame_start_reg <= 1'b1;
                        busy_reg        <= 1'b1;
                    end
                end
                ST_FSTART: begin
                    light_reg <= '{x: l_loc_x_i, y: l_loc_y_i, z: l_loc_z_i};
                    x_reg     <= '0;
                    y_reg     <= '0;
                    state_reg <= ST_WAIT_CRED;
                end
                ST_WAIT_CRED: begin
                    if (credit_avail) begin
                        state_reg     <= ST_RUN;
                        run_reg       <= 1'b1;
                        row_start_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (x_reg == X_W'(X_PIXELS - 1)) begin
                        x_reg   <= '0;
                        run_reg <= 1'b0;
                        if (y_reg == Y_W'(Y_PIXELS - 1)) begin
                            // Last pixel issued: count PIPE_LEN cycles to the done pulse.
                            state_reg <= ST_DRAIN;
                            drain_reg <= DRAIN_W'(PIPE_LEN - 2);
                        end else begin
                            y_reg     <= y_reg + Y_W'(1);
                            state_reg <= ST_WAIT_CRED;
                        end
                    end else begin
                        x_reg <= x_reg + X_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_reg == '0) begin
                        state_reg      <= ST_FDONE;
                        frame_done_reg <= 1'b1;
                    end else begin
                        drain_reg <= drain_reg - DRAIN_W'(1);
                    end
                end
                ST_FDONE: begin
                    if (enable_i) begin
                        state_reg       <= ST_FSTART;
                        frame_start_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    run_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign run_o         = run_reg;
    assign x_coord_o     = x_reg;
    assign y_coord_o     = y_reg;
    assign row_start_o   = row_start_reg;
    assign frame_start_o = frame_start_reg;
    assign frame_done_o  = frame_done_reg;
    assign busy_o        = busy_reg;
    assign l_loc_x_o     = light_reg.x;
    assign l_loc_y_o     = light_reg.y;
    assign l_loc_z_o     = light_reg.z;

endmodule

// File: tb/tb_rt_frame_scheduler.sv
// Directed bench for rt_frame_scheduler with X=4, Y=3, PIPE_LEN=5, CREDITS=2.
module tb_rt_frame_scheduler;

    localparam logic [31:0] EXP_QCBRT_2 = 32'h0001_428A;

    logic        clk;
    logic        rst;
    logic        enable_i;
    logic        fb_row_free_i;
    logic [31:0] l_loc_x_i;
    logic [31:0] l_loc_y_i;
    logic [31:0] l_loc_z_i;
    logic        run_o;
    logic [1:0]  x_coord_o;
    logic [1:0]  y_coord_o;
    logic        row_start_o;
    logic        frame_start_o;
    logic        frame_done_o;
    logic [31:0] l_loc_x_o;
    logic [31:0] l_loc_y_o;
    logic [31:0] l_loc_z_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    rt_frame_scheduler #(
        .X_PIXELS  (4),
        .Y_PIXELS  (3),
        .PIPE_LEN  (5),
        .CREDITS   (2),
        .LOC_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .fb_row_free_i (fb_row_free_i),
        .l_loc_x_i     (l_loc_x_i),
        .l_loc_y_i     (l_loc_y_i),
        .l_loc_z_i     (l_loc_z_i),
        .run_o         (run_o),
        .x_coord_o     (x_coord_o),
        .y_coord_o     (y_coord_o),
        .row_start_o   (row_start_o),
        .frame_start_o (frame_start_o),
        .frame_done_o  (frame_done_o),
        .l_loc_x_o     (l_loc_x_o),
        .l_loc_y_o     (l_loc_y_o),
        .l_loc_z_o     (l_loc_z_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks one 4-pixel row starting at a sampling point; give_mask[i]
    // pulses fb_row_free_i during pixel i.
    task automatic run_row(input int yy, input logic [3:0] give_mask);
        for (int xi = 0; xi < 4; xi++) begin
            chk($sformatf("run y%0d x%0d", yy, xi), run_o, 1);
            chk($sformatf("x y%0d x%0d", yy, xi), x_coord_o, xi);
            chk($sformatf("y y%0d x%0d", yy, xi), y_coord_o, yy);
            chk($sformatf("row_start y%0d x%0d", yy, xi), row_start_o, (xi == 0) ? 1 : 0);
            chk($sformatf("busy y%0d x%0d", yy, xi), busy_o, 1);
            fb_row_free_i = give_mask[xi];
            tick();
            fb_row_free_i = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; enable_i = 1'b0; fb_row_free_i = 1'b0;
        l_loc_x_i = 32'h100; l_loc_y_i = 32'h11; l_loc_z_i = 32'h22;
        tick(); tick();

        // Reset state
        chk("rst run", run_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst x", x_coord_o, 0);
        chk("rst y", y_coord_o, 0);
        chk("rst frame_start", frame_start_o, 0);
        chk("rst frame_done", frame_done_o, 0);
        chk("rst row_start", row_start_o, 0);
        chk("rst l_loc_x", l_loc_x_o, EXP_QCBRT_2);
        chk("rst l_loc_z", l_loc_z_o, EXP_QCBRT_2);
        chk("rst credits", dut.credit_count, 2);

        // Frame 1: basic frame, credit returned on each row's first pixel
        rst = 1'b0; enable_i = 1'b1;
        tick();
        chk("f1 frame_start", frame_start_o, 1);
        chk("f1 busy", busy_o, 1);
        chk("f1 run in FSTART", run_o, 0);
        tick();
        chk("f1 frame_start pulse end", frame_start_o, 0);
        chk("f1 l_loc_x latched", l_loc_x_o, 32'h100);
        chk("f1 l_loc_y latched", l_loc_y_o, 32'h11);
        tick();
        run_row(0, 4'b0001);
        chk("f1 bubble0 run", run_o, 0);
        l_loc_x_i = 32'h200;
        tick();
        run_row(1, 4'b0001);
        chk("f1 bubble1 run", run_o, 0);
        chk("f1 l_loc_x held", l_loc_x_o, 32'h100);
        tick();
        run_row(2, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("f1 drain%0d done", i), frame_done_o, 0);
            chk($sformatf("f1 drain%0d run", i), run_o, 0);
            chk($sformatf("f1 drain%0d busy", i), busy_o, 1);
            tick();
        end
        chk("f1 frame_done at +5", frame_done_o, 1);
        chk("f1 credits full", dut.credit_count, 2);
        tick();
        chk("b2b frame_start", frame_start_o, 1);
        chk("b2b frame_done pulse end", frame_done_o, 0);
        chk("b2b l_loc_x before latch", l_loc_x_o, 32'h100);
        tick();
        chk("f2 l_loc_x new", l_loc_x_o, 32'h200);
        chk("f2 frame_start pulse end", frame_start_o, 0);
        tick();

        // Frame 2: no credit returns, stall before row 2; enable dropped in row 1
        run_row(0, 4'b0000);
        chk("f2 credits after row0", dut.credit_count, 1);
        tick();
        enable_i = 1'b0;
        run_row(1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d run", i), run_o, 0);
            chk($sformatf("stall%0d y", i), y_coord_o, 2);
            chk($sformatf("stall%0d credits", i), dut.credit_count, 0);
            chk($sformatf("stall%0d busy", i), busy_o, 1);
            if (i < 2) tick();
        end
        fb_row_free_i = 1'b1;
        tick();
        fb_row_free_i = 1'b0;
        chk("stall release credits", dut.credit_count, 0);
        run_row(2, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("f2 drain%0d done", i), frame_done_o, 0);
            tick();
        end
        chk("f2 frame_done", frame_done_o, 1);
        tick();
        chk("idle busy", busy_o, 0);
        chk("idle frame_start", frame_start_o, 0);
        chk("idle run", run_o, 0);

        // Frame 3: simultaneous issue/free at credits=1, then overflow
        fb_row_free_i = 1'b1;
        tick();
        fb_row_free_i = 1'b0;
        chk("idle credit return", dut.credit_count, 1);
        enable_i = 1'b1;
        tick();
        chk("f3 frame_start", frame_start_o, 1);
        tick();
        fb_row_free_i = 1'b1;
        tick();
        fb_row_free_i = 1'b0;
        chk("simul credits", dut.credit_count, 1);
        run_row(0, 4'b0000);
        chk("f3 bubble run", run_o, 0);
        chk("f3 bubble credits", dut.credit_count, 1);
        tick();
        run_row(1, 4'b0111);
        chk("overflow credits", dut.credit_count, 2);
        chk("overflow flag", dut.credit_overflow_reg, 1);
        tick();
        chk("f3 row2 run", run_o, 1);
        chk("f3 row2 row_start", row_start_o, 1);
        chk("f3 row2 y", y_coord_o, 2);
        chk("f3 row2 credits", dut.credit_count, 1);
        chk("f3 l_loc_x", l_loc_x_o, 32'h200);

        // Reset during RUN aborts the frame
        rst = 1'b1; enable_i = 1'b0;
        tick();
        chk("abort run", run_o, 0);
        chk("abort x", x_coord_o, 0);
        chk("abort y", y_coord_o, 0);
        chk("abort credits", dut.credit_count, 2);
        chk("abort l_loc_x", l_loc_x_o, EXP_QCBRT_2);
        chk("abort l_loc_y", l_loc_y_o, EXP_QCBRT_2);
        chk("abort busy", busy_o, 0);
        chk("abort overflow clr", dut.credit_overflow_reg, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("post-abort%0d done", i), frame_done_o, 0);
            chk($sformatf("post-abort%0d busy", i), busy_o, 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
